// File: rtl/bitstream_window.sv
// bitstream_window
//   Bit reservoir that accepts IN_W-bit words and exposes the oldest WIN_W
//   unconsumed bits as a left-justified window. A consumer removes bits either
//   by an explicit count (ShiftEn/NumShift) or by skipping to the next byte
//   boundary of the consumed-bit count (AlignEn). Consume and load may happen
//   in the same cycle; the load lands right after the bits that survive the
//   consume.
//
// Ports
//   Clk         in   clock, rising edge
//   nReset      in   asynchronous active-low reset
//   Enable      in   block enable; low flushes all state every cycle
//   InData      in   IN_W  input word, MSB is the oldest bit
//   InValid     in   InData is valid
//   InReady     out  word is accepted this cycle (room for a full word)
//   ShiftEn     in   consume NumShift bits
//   NumShift    in   SW    bits to consume, values above WIN_W clamp to WIN_W
//   AlignEn     in   consume up to the next byte boundary (wins over ShiftEn)
//   Window      out  WIN_W oldest unconsumed bits, zero padded past Fill
//   WindowValid out  Fill >= WIN_W
//   Fill        out  FW    number of unconsumed bits held
//   BitCount    out  32    bits consumed since flush, wraps
//   Underrun    out  sticky: a consume asked for more bits than were held
//
// Handshake: a word transfers on a rising edge where InValid and InReady are
// both high. InReady depends only on Enable and the registered Fill, never on
// InValid or on a same-cycle consume, so the producer may hold InValid high
// with a stable InData until it sees the transfer.
module bitstream_window #(
  parameter int IN_W  = 16,
  parameter int WIN_W = 16,
  parameter int DEPTH = 4,
  localparam int BUF_W = IN_W * DEPTH,
  localparam int SW    = $clog2(WIN_W + 1),
  localparam int FW    = $clog2(BUF_W + 1)
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             Enable,
  input  logic [IN_W-1:0]  InData,
  input  logic             InValid,
  output logic             InReady,
  input  logic             ShiftEn,
  input  logic [SW-1:0]    NumShift,
  input  logic             AlignEn,
  output logic [WIN_W-1:0] Window,
  output logic             WindowValid,
  output logic [FW-1:0]    Fill,
  output logic [31:0]      BitCount,
  output logic             Underrun
);

  logic [BUF_W-1:0] r_buf;
  logic [FW-1:0]    r_fill;
  logic [31:0]      r_bit_count;
  logic             r_underrun;

  logic             w_room;
  logic             w_load;
  logic [2:0]       w_align_amt;
  logic [FW-1:0]    w_shift_amt;
  logic [FW-1:0]    w_req;
  logic             w_over;
  logic [FW-1:0]    w_c;
  logic [FW-1:0]    w_rem;
  logic [BUF_W-1:0] w_kept;
  logic [BUF_W-1:0] w_append;
  logic [BUF_W-1:0] w_buf_nxt;
  logic [FW-1:0]    w_fill_nxt;

  always_comb begin
    w_room      = 1'b0;
    w_load      = 1'b0;
    w_align_amt = 3'd0;
    w_shift_amt = '0;
    w_req       = '0;
    w_over      = 1'b0;
    w_c         = '0;
    w_rem       = '0;
    w_kept      = '0;
    w_append    = '0;
    w_buf_nxt   = '0;
    w_fill_nxt  = '0;

    // Room for a whole word, judged from the registered fill only.
    w_room = (r_fill <= FW'(BUF_W - IN_W));
    // nReset gates the output so InReady reads 0 while reset is held, even
    // if Enable is already high.
    InReady = nReset & Enable & w_room;
    w_load  = InValid & InReady;

    // (8 - BitCount%8) % 8 is just the 3-bit two's complement of the low bits.
    w_align_amt = 3'd0 - r_bit_count[2:0];
    w_shift_amt = (NumShift > SW'(WIN_W)) ? FW'(WIN_W) : FW'(NumShift);

    if (AlignEn) begin
      w_req = FW'(w_align_amt);
    end else if (ShiftEn) begin
      w_req = w_shift_amt;
    end

    // An oversized request consumes nothing; a load in the same cycle still
    // proceeds against the untouched contents.
    w_over = (w_req > r_fill);
    w_c    = w_over ? '0 : w_req;

    // Left shift brings zeros in at the bottom, which keeps every bit past
    // the fill level at 0 so the append can simply be OR-ed in.
    w_kept   = r_buf << w_c;
    w_rem    = r_fill - w_c;
    w_append = {InData, {(BUF_W - IN_W){1'b0}}} >> w_rem;

    w_buf_nxt  = w_load ? (w_kept | w_append) : w_kept;
    w_fill_nxt = w_rem + (w_load ? FW'(IN_W) : FW'(0));
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_buf       <= '0;
      r_fill      <= '0;
      r_bit_count <= '0;
      r_underrun  <= 1'b0;
    end else if (!Enable) begin
      r_buf       <= '0;
      r_fill      <= '0;
      r_bit_count <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_buf       <= w_buf_nxt;
      r_fill      <= w_fill_nxt;
      r_bit_count <= r_bit_count + 32'(w_c);
      r_underrun  <= r_underrun | w_over;
    end
  end

  assign Window      = r_buf[BUF_W-1 -: WIN_W];
  assign WindowValid = (r_fill >= FW'(WIN_W));
  assign Fill        = r_fill;
  assign BitCount    = r_bit_count;
  assign Underrun    = r_underrun;

endmodule

// File: tb/tb_bitstream_window.sv
// Self-checking bench for bitstream_window with default parameters.
// Directed vectors come from a table of {inputs, expected outputs}; a short
// reset-in-flight sequence is hand written; a random phase compares against
// a bit-queue reference model. Every expectation goes through exp_q.
module tb_bitstream_window;

  localparam int IN_W  = 16;
  localparam int WIN_W = 16;
  localparam int DEPTH = 4;
  localparam int BUF_W = IN_W * DEPTH;
  localparam int SW    = $clog2(WIN_W + 1);
  localparam int FW    = $clog2(BUF_W + 1);
  localparam int EW    = 3 + WIN_W + FW + 32;

  // ---------------- clock / reset / DUT ----------------
  logic             Clk = 1'b0;
  logic             nReset;
  logic             Enable;
  logic [IN_W-1:0]  InData;
  logic             InValid;
  logic             InReady;
  logic             ShiftEn;
  logic [SW-1:0]    NumShift;
  logic             AlignEn;
  logic [WIN_W-1:0] Window;
  logic             WindowValid;
  logic [FW-1:0]    Fill;
  logic [31:0]      BitCount;
  logic             Underrun;

  always #5 Clk = ~Clk;

  bitstream_window #(.IN_W(IN_W), .WIN_W(WIN_W), .DEPTH(DEPTH)) dut (
    .Clk         (Clk),
    .nReset      (nReset),
    .Enable      (Enable),
    .InData      (InData),
    .InValid     (InValid),
    .InReady     (InReady),
    .ShiftEn     (ShiftEn),
    .NumShift    (NumShift),
    .AlignEn     (AlignEn),
    .Window      (Window),
    .WindowValid (WindowValid),
    .Fill        (Fill),
    .BitCount    (BitCount),
    .Underrun    (Underrun)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic             en;
    logic             iv;
    logic [IN_W-1:0]  data;
    logic             se;
    logic [SW-1:0]    ns;
    logic             ae;
    logic [WIN_W-1:0] win;
    logic             wv;
    logic [FW-1:0]    fill;
    logic [31:0]      bc;
    logic             un;
    logic             rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic iv, input logic [IN_W-1:0] data,
                              input logic se, input logic [SW-1:0] ns, input logic ae,
                              input logic [WIN_W-1:0] win, input logic wv,
                              input logic [FW-1:0] fill, input logic [31:0] bc,
                              input logic un, input logic rdy);
    vec_t v;
    v.en = en; v.iv = iv; v.data = data; v.se = se; v.ns = ns; v.ae = ae;
    v.win = win; v.wv = wv; v.fill = fill; v.bc = bc; v.un = un; v.rdy = rdy;
    vecs.push_back(v);
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [EW-1:0] pack_exp(input logic rdy, input logic un, input logic wv,
                                             input logic [WIN_W-1:0] win,
                                             input logic [FW-1:0] fill, input logic [31:0] bc);
    return {rdy, un, wv, win, fill, bc};
  endfunction

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h expected=%h", tag, name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [EW-1:0]    e;
    logic             e_rdy, e_un, e_wv;
    logic [WIN_W-1:0] e_win;
    logic [FW-1:0]    e_fill;
    logic [31:0]      e_bc;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.scoreboard actual=empty expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    {e_rdy, e_un, e_wv, e_win, e_fill, e_bc} = e;
    chk(tag, "window",   32'(Window),      32'(e_win));
    chk(tag, "wvalid",   32'(WindowValid), 32'(e_wv));
    chk(tag, "fill",     32'(Fill),        32'(e_fill));
    chk(tag, "bitcount", BitCount,         e_bc);
    chk(tag, "underrun", 32'(Underrun),    32'(e_un));
    chk(tag, "in_ready", 32'(InReady),     32'(e_rdy));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic en, input logic iv, input logic [IN_W-1:0] data,
                       input logic se, input logic [SW-1:0] ns, input logic ae);
    Enable   = en;
    InValid  = iv;
    InData   = data;
    ShiftEn  = se;
    NumShift = ns;
    AlignEn  = ae;
  endtask

  // Inputs are driven at the falling edge; outputs are sampled at the next
  // falling edge with the same inputs still applied.
  task automatic run_cycle(input string tag);
    @(posedge Clk);
    @(negedge Clk);
    check_outputs(tag);
  endtask

  // ---------------- reference model ----------------
  bit          m_bits[$];
  int unsigned m_bc;
  logic        m_un;

  task automatic model_step(input logic en, input logic iv, input logic [IN_W-1:0] data,
                            input logic se, input logic [SW-1:0] ns, input logic ae,
                            output logic [EW-1:0] e);
    int               sz;
    int               c;
    logic             rdy_pre;
    logic [WIN_W-1:0] win;
    sz      = m_bits.size();
    rdy_pre = en && ((BUF_W - sz) >= IN_W);
    if (!en) begin
      m_bits.delete();
      m_bc = 0;
      m_un = 1'b0;
    end else begin
      if (ae)      c = (8 - int'(m_bc % 8)) % 8;
      else if (se) c = (int'(ns) > WIN_W) ? WIN_W : int'(ns);
      else         c = 0;
      if (c > sz) begin
        m_un = 1'b1;
      end else begin
        for (int k = 0; k < c; k++) void'(m_bits.pop_front());
        m_bc += c;
      end
      if (iv && rdy_pre)
        for (int i = IN_W - 1; i >= 0; i--) m_bits.push_back(data[i]);
    end
    win = '0;
    for (int i = 0; i < WIN_W; i++)
      if (i < m_bits.size()) win[WIN_W-1-i] = m_bits[i];
    e = pack_exp(en && ((BUF_W - m_bits.size()) >= IN_W), m_un,
                 m_bits.size() >= WIN_W, win, FW'(m_bits.size()), m_bc);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- main test ----------------
  initial begin
    logic [EW-1:0] e;
    logic          r_en, r_iv, r_se, r_ae;
    logic [IN_W-1:0] r_data;
    logic [SW-1:0]   r_ns;

    // Row: en iv data se ns ae | window wv fill bc un rdy
    // basic load / load+shift / align / no-ops, then flush with fill 40
    add(0,0,16'h0000,0,0,0, 16'h0000,0, 0, 0,0,0);
    add(1,0,16'h0000,0,0,0, 16'h0000,0, 0, 0,0,1);
    add(1,1,16'hA5C3,0,0,0, 16'hA5C3,1,16, 0,0,1);
    add(1,1,16'h1234,1,4,0, 16'h5C31,1,28, 4,0,1);
    add(1,1,16'h1111,0,0,0, 16'h5C31,1,44, 4,0,1);
    add(1,0,16'h0000,1,16,0,16'h2341,1,28,20,0,1);
    add(1,0,16'h0000,0,0,1, 16'h3411,1,24,24,0,1);
    add(1,0,16'h0000,0,0,1, 16'h3411,1,24,24,0,1);
    add(1,0,16'h0000,1,0,0, 16'h3411,1,24,24,0,1);
    add(1,1,16'h5678,0,0,0, 16'h3411,1,40,24,0,1);
    add(0,1,16'hFFFF,1,4,0, 16'h0000,0, 0, 0,0,0);
    // full reservoir back-pressure and NumShift clamp
    add(1,0,16'h0000,0,0,0, 16'h0000,0, 0, 0,0,1);
    add(1,1,16'h0001,0,0,0, 16'h0001,1,16, 0,0,1);
    add(1,1,16'h0002,0,0,0, 16'h0001,1,32, 0,0,1);
    add(1,1,16'h0003,0,0,0, 16'h0001,1,48, 0,0,1);
    add(1,1,16'h0004,0,0,0, 16'h0001,1,64, 0,0,0);
    add(1,1,16'h0005,1,16,0,16'h0002,1,48,16,0,1);
    add(1,1,16'h0005,0,0,0, 16'h0002,1,64,16,0,0);
    add(1,1,16'h0006,0,0,0, 16'h0002,1,64,16,0,0);
    add(1,0,16'h0000,1,16,0,16'h0003,1,48,32,0,1);
    add(1,0,16'h0000,1,16,0,16'h0004,1,32,48,0,1);
    add(1,0,16'h0000,1,16,0,16'h0005,1,16,64,0,1);
    add(1,0,16'h0000,1,31,0,16'h0000,0, 0,80,0,1);
    // align beats shift
    add(0,0,16'h0000,0,0,0, 16'h0000,0, 0, 0,0,0);
    add(1,1,16'hABCD,0,0,0, 16'hABCD,1,16, 0,0,1);
    add(1,1,16'h1234,1,5,0, 16'h79A2,1,27, 5,0,1);
    add(1,0,16'h0000,1,7,1, 16'hCD12,1,24, 8,0,1);
    add(1,0,16'h0000,0,0,1, 16'hCD12,1,24, 8,0,1);
    // underrun is sticky and leaves contents alone
    add(0,0,16'h0000,0,0,0, 16'h0000,0, 0, 0,0,0);
    add(1,1,16'hABCD,0,0,0, 16'hABCD,1,16, 0,0,1);
    add(1,0,16'h0000,1,6,0, 16'hF340,0,10, 6,0,1);
    add(1,0,16'h0000,1,12,0,16'hF340,0,10, 6,1,1);
    add(1,0,16'h0000,0,0,0, 16'hF340,0,10, 6,1,1);
    add(1,0,16'h0000,1,10,0,16'h0000,0, 0,16,1,1);
    add(1,1,16'h00FF,0,0,0, 16'h00FF,1,16,16,1,1);
    // underrun with a same-cycle load: load still happens
    add(0,0,16'h0000,0,0,0, 16'h0000,0, 0, 0,0,0);
    add(1,1,16'h8001,1,3,0, 16'h8001,1,16, 0,1,1);
    add(0,0,16'h0000,0,0,0, 16'h0000,0, 0, 0,0,0);
    // partial contents ahead of an asynchronous reset
    add(1,1,16'h1357,0,0,0, 16'h1357,1,16, 0,0,1);
    add(1,1,16'h2468,0,0,0, 16'h1357,1,32, 0,0,1);

    // Reset held with Enable already high: everything reads 0.
    nReset = 1'b0;
    drive(1, 0, '0, 0, 0, 0);
    @(negedge Clk);
    exp_q.push_back(pack_exp(0, 0, 0, '0, '0, '0));
    check_outputs("reset");
    Enable = 1'b0;
    nReset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].iv, vecs[i].data, vecs[i].se, vecs[i].ns, vecs[i].ae);
      exp_q.push_back(pack_exp(vecs[i].rdy, vecs[i].un, vecs[i].wv, vecs[i].win,
                               vecs[i].fill, vecs[i].bc));
      run_cycle($sformatf("vec%0d", i));
    end

    // Reset pulsed while a load is being presented: outputs clear at once.
    drive(1, 1, 16'h9999, 0, 0, 0);
    #2 nReset = 1'b0;
    #1;
    exp_q.push_back(pack_exp(0, 0, 0, '0, '0, '0));
    check_outputs("async_rst");
    @(posedge Clk);
    @(negedge Clk);
    exp_q.push_back(pack_exp(0, 0, 0, '0, '0, '0));
    check_outputs("rst_hold");
    drive(1, 0, '0, 0, 0, 0);
    nReset = 1'b1;
    exp_q.push_back(pack_exp(1, 0, 0, '0, '0, '0));
    run_cycle("rst_release");

    // Random traffic against the reference model, starting empty.
    m_bits.delete();
    m_bc = 0;
    m_un = 1'b0;
    for (int n = 0; n < 400; n++) begin
      r_en   = ($urandom_range(0, 29) != 0);
      r_iv   = ($urandom_range(0, 1) == 1);
      r_data = IN_W'($urandom());
      r_se   = ($urandom_range(0, 1) == 1);
      r_ns   = SW'($urandom_range(0, 20));
      r_ae   = ($urandom_range(0, 5) == 0);
      drive(r_en, r_iv, r_data, r_se, r_ns, r_ae);
      model_step(r_en, r_iv, r_data, r_se, r_ns, r_ae, e);
      exp_q.push_back(e);
      run_cycle($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitstream_window.md
BITSTREAM_WINDOW -- requirements
Module: bitstream_window

Interface
REQ-001 Parameters: IN_W (default 16) is the input word width in bits; WIN_W (default 16) is the output window width in bits; DEPTH (default 4) is the reservoir depth in input words; BUF_W = IN_W*DEPTH.
REQ-002 Legal parameters SHALL satisfy DEPTH>=2 and WIN_W<=BUF_W-IN_W; SW = $clog2(WIN_W+1) and FW = $clog2(BUF_W+1).
REQ-003 Clk  in  1  clock; all logic is on the rising edge.
REQ-004 nReset  in  1  reset, asynchronous, active-low.
REQ-005 Enable  in  1  block enable; low flushes all state.
REQ-006 InData  in  IN_W  input word, MSB is the oldest bit.
REQ-007 InValid  in  1  InData is valid.
REQ-008 InReady  out  1  block accepts InData this cycle.
REQ-009 ShiftEn  in  1  consume NumShift bits.
REQ-010 NumShift  in  SW  bits to consume, 0..WIN_W.
REQ-011 AlignEn  in  1  consume bits up to the next byte boundary.
REQ-012 Window  out  WIN_W  oldest WIN_W unconsumed bits, left-justified.
REQ-013 WindowValid  out  1  at least WIN_W bits are held (Fill>=WIN_W).
REQ-014 Fill  out  FW  number of unconsumed bits held.
REQ-015 BitCount  out  32  total bits consumed since flush.
REQ-016 Underrun  out  1  sticky error flag: a consume request exceeded Fill.

Function
REQ-017 Storage SHALL be a BUF_W-bit register Buf; the oldest unconsumed bit is always Buf[BUF_W-1]; Window = Buf[BUF_W-1 -: WIN_W], driven directly from the register.
REQ-018 InReady SHALL equal Enable & (BUF_W-Fill >= IN_W), computed from the registered Fill only; same-cycle consumption does not raise InReady.
REQ-019 A load occurs when InValid & InReady; InData SHALL be placed immediately after the last unconsumed bit remaining after any same-cycle consume.
REQ-020 Consume amount C per cycle: AlignEn gives C = (8 - BitCount%8)%8; otherwise ShiftEn gives C = NumShift; otherwise C = 0.
REQ-021 AlignEn SHALL take priority over ShiftEn; when both are high, ShiftEn is ignored that cycle.
REQ-022 NumShift > WIN_W SHALL be treated as WIN_W.
REQ-023 If C > Fill: no bits are consumed, Underrun is set, Buf, Fill and BitCount are unchanged by the consume, and a same-cycle load still occurs.
REQ-024 A legal consume SHALL left-shift Buf by C, reduce Fill by C and add C to BitCount, which wraps modulo 2^32.
REQ-025 For a simultaneous consume and load: Fill' = Fill - C + IN_W, and Buf' places consume-then-append data in one cycle.
REQ-026 Latency: the effect of a consume or load at edge t SHALL be visible on Window, WindowValid, Fill and BitCount from edge t onward, i.e. one cycle after the request is presented.
REQ-027 Bits of Buf beyond Fill SHALL read as 0, so Window is zero-padded when WindowValid is 0.
REQ-028 While Enable=0, synchronously every cycle: Buf=0, Fill=0, BitCount=0, Underrun=0; loads and consumes are ignored.
REQ-029 A consume with C=0 (NumShift=0, or AlignEn when already aligned) SHALL be a legal no-op with no Underrun.

Reset
REQ-030 On nReset low, immediately: Buf=0, Fill=0, BitCount=0, Underrun=0, WindowValid=0, Window=0, InReady=0.
REQ-031 Reset asserted mid-operation SHALL discard all held bits; there is no recovery of partial data.

Verification
REQ-032 Reset with Enable=0 -> all outputs 0; raise Enable -> InReady=1 on the next cycle, with Fill=0.
REQ-033 Load 0xA5C3 -> next cycle Window=0xA5C3, WindowValid=1, Fill=16; load 0x1234 together with ShiftEn NumShift=4 -> Window=0x5C31, Fill=28, BitCount=4.
REQ-034 Load four words -> Fill=64, InReady=0; ShiftEn NumShift=16 with InValid high -> that word is not accepted; the word is accepted the cycle after, with Fill returning to 64.
REQ-035 BitCount=5, Fill=20, assert AlignEn and ShiftEn NumShift=7 -> consumes 3 bits only: BitCount=8, Fill=17.
REQ-036 Fill=10, ShiftEn NumShift=12 -> Underrun=1, Fill=10, Window unchanged; Underrun stays 1 until Enable=0.
REQ-037 Enable dropped with Fill=40 -> next cycle Fill=0, BitCount=0, Window=0, InReady=0; nReset pulsed mid-load -> all outputs 0 asynchronously.
